// File: rtl/alu_op_scheduler_pkg.sv
// Shared ALU op encoding, per-op latency table and scheduler state type.
package common_pkg;

    // ALU operations; encodings 23..31 are unused and treated as single-cycle.
    typedef enum logic [4:0] {
        ALU_ADD         = 5'd0,
        ALU_SUB         = 5'd1,
        ALU_AND         = 5'd2,
        ALU_OR          = 5'd3,
        ALU_XOR         = 5'd4,
        ALU_SLL         = 5'd5,
        ALU_SRL         = 5'd6,
        ALU_SRA         = 5'd7,
        ALU_SLT         = 5'd8,
        ALU_SLTU        = 5'd9,
        ALU_MUL         = 5'd10,
        ALU_MULH        = 5'd11,
        ALU_DIV         = 5'd12,
        ALU_DIVU        = 5'd13,
        ALU_REM         = 5'd14,
        ALU_REMU        = 5'd15,
        ALU_F_ADD       = 5'd16,
        ALU_F_SUB       = 5'd17,
        ALU_F_MUL       = 5'd18,
        ALU_F_DIV       = 5'd19,
        ALU_F_SQRT      = 5'd20,
        ALU_F_INT_FLOAT = 5'd21,
        ALU_F_FLOAT_INT = 5'd22
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    localparam int LAT_W    = 6;
    localparam int LAT_FADD = 2;
    localparam int LAT_MUL  = 6;
    localparam int LAT_DIV  = 32;
    localparam int LAT_FDIV = 36;

    // Cycles the ALU needs for an op; 0 means the result is ready in the issue cycle.
    function automatic logic [LAT_W-1:0] alu_latency(input alu_op_t op);
        logic [LAT_W-1:0] lat;
        case (op)
            ALU_F_ADD, ALU_F_SUB, ALU_F_FLOAT_INT:         lat = LAT_W'(LAT_FADD);
            ALU_MUL, ALU_MULH, ALU_F_MUL:                  lat = LAT_W'(LAT_MUL);
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
            ALU_F_INT_FLOAT:                               lat = LAT_W'(LAT_DIV);
            ALU_F_DIV, ALU_F_SQRT:                         lat = LAT_W'(LAT_FDIV);
            default:                                       lat = '0;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/alu_op_scheduler_if.sv
// Issue/completion bus between decode (master) and the ALU op scheduler (slave).
// Handshake: an op is taken in any cycle where issue_valid and issue_ready are
// both high; issue_ready never depends on issue_valid, and op_done/done_op
// report a completed op for exactly one cycle. state is a debug view of the FSM.
interface alu_sched_if;
    import common_pkg::*;

    logic         issue_valid;
    alu_op_t      issue_op;
    logic         flush;
    logic         issue_ready;
    logic         stall;
    logic         op_done;
    alu_op_t      done_op;
    logic [31:0]  stall_cycles;
    sched_state_t state;

    modport master (
        output issue_valid, issue_op, flush,
        input  issue_ready, stall, op_done, done_op, stall_cycles, state
    );

    modport slave (
        input  issue_valid, issue_op, flush,
        output issue_ready, stall, op_done, done_op, stall_cycles, state
    );

endinterface

// File: rtl/alu_op_scheduler.sv
// Sequences multi-cycle ALU ops: stalls upstream for the op's latency and
// flags completion. Single-cycle ops complete combinationally in the issue cycle.
module alu_op_scheduler
    import common_pkg::*;
#(
    parameter int CNT_W = 6   // must hold LAT_FDIV-1; keep at 6 or more
) (
    input  logic  clk,
    input  logic  rst_n,
    alu_sched_if.slave bus
);

    sched_state_t     state_q;
    logic [CNT_W-1:0] cnt_q;
    alu_op_t          op_q;
    logic [31:0]      stall_cnt_q;

    logic [LAT_W-1:0] lat;
    logic             ready;
    logic             accept;
    logic             stall;
    logic             done;
    alu_op_t          done_op;

    assign lat = alu_latency(bus.issue_op);

    // Output decode: everything is gated by reset and flush, which win over all events.
    always_comb begin
        ready   = rst_n && (state_q != BUSY) && !bus.flush;
        accept  = bus.issue_valid && ready;
        stall   = 1'b0;
        done    = 1'b0;
        done_op = op_q;
        if (rst_n && !bus.flush) begin
            stall = (state_q == BUSY) || (accept && (lat != '0));
            // A single-cycle op accepted in DONE reports itself; otherwise the
            // registered multi-cycle op is the one finishing.
            if (accept && (lat == '0)) begin
                done    = 1'b1;
                done_op = bus.issue_op;
            end else if (state_q == DONE) begin
                done = 1'b1;
            end
        end
    end

    // Scheduler FSM with its latency down-counter and the tracked op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= ALU_ADD;
        end else if (bus.flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept && (lat != '0)) begin
                        state_q <= BUSY;
                        cnt_q   <= CNT_W'(lat - LAT_W'(1));
                        op_q    <= bus.issue_op;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Saturating count of stalled cycles; survives flush, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.issue_ready  = ready;
    assign bus.stall        = stall;
    assign bus.op_done      = done;
    assign bus.done_op      = done_op;
    assign bus.stall_cycles = stall_cnt_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed bench for alu_op_scheduler: latency table per op plus hand-built
// sequences for back-to-back issue, flush, mid-op reset and counter saturation.
module tb_alu_op_scheduler;
    import common_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [31:0] exp_sc;

    alu_sched_if bus();

    alu_op_scheduler #(.CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input alu_op_t op, input logic f);
        bus.issue_valid = v;
        bus.issue_op    = op;
        bus.flush       = f;
    endtask

    // Inputs change on the falling edge; outputs are checked 1ns later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    typedef struct {
        string   name;
        alu_op_t op;
        int      lat;
    } lat_vec_t;

    lat_vec_t vecs[15];

    initial begin
        checks = 0;
        errors = 0;
        exp_sc = 32'd0;

        vecs[0]  = '{"add",      ALU_ADD,          0};
        vecs[1]  = '{"sub",      ALU_SUB,          0};
        vecs[2]  = '{"xor",      ALU_XOR,          0};
        vecs[3]  = '{"mul",      ALU_MUL,          6};
        vecs[4]  = '{"mulh",     ALU_MULH,         6};
        vecs[5]  = '{"fmul",     ALU_F_MUL,        6};
        vecs[6]  = '{"fadd",     ALU_F_ADD,        2};
        vecs[7]  = '{"fsub",     ALU_F_SUB,        2};
        vecs[8]  = '{"f2i",      ALU_F_FLOAT_INT,  2};
        vecs[9]  = '{"div",      ALU_DIV,          32};
        vecs[10] = '{"remu",     ALU_REMU,         32};
        vecs[11] = '{"i2f",      ALU_F_INT_FLOAT,  32};
        vecs[12] = '{"fdiv",     ALU_F_DIV,        36};
        vecs[13] = '{"fsqrt",    ALU_F_SQRT,       36};
        vecs[14] = '{"illegal",  alu_op_t'(5'd30), 0};

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        drive(1'b0, ALU_ADD, 1'b0);
        #3;
        chk("rst_ready", 32'(bus.issue_ready), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_done", 32'(bus.op_done), 32'd0);
        chk("rst_sc", bus.stall_cycles, 32'd0);
        chk("rst_state", 32'(bus.state), 32'(IDLE));
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        #1;
        chk("idle_ready", 32'(bus.issue_ready), 32'd1);
        chk("idle_stall", 32'(bus.stall), 32'd0);
        chk("idle_done", 32'(bus.op_done), 32'd0);
        next_cycle();
        #1;
        chk("idle_hold_state", 32'(bus.state), 32'(IDLE));
        next_cycle();

        // ---------------- latency table ----------------
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, vecs[i].op, 1'b0);
            #1;
            chk({vecs[i].name, "_issue_ready"}, 32'(bus.issue_ready), 32'd1);
            chk({vecs[i].name, "_issue_stall"}, 32'(bus.stall), 32'(vecs[i].lat != 0));
            chk({vecs[i].name, "_issue_done"}, 32'(bus.op_done), 32'(vecs[i].lat == 0));
            if (vecs[i].lat == 0) begin
                chk({vecs[i].name, "_issue_done_op"}, 32'(bus.done_op), 32'(vecs[i].op));
                next_cycle();
                drive(1'b0, ALU_ADD, 1'b0);
                #1;
                chk({vecs[i].name, "_after_ready"}, 32'(bus.issue_ready), 32'd1);
                chk({vecs[i].name, "_after_sc"}, bus.stall_cycles, exp_sc);
            end else begin
                for (int c = 1; c < vecs[i].lat; c++) begin
                    next_cycle();
                    // A different op presented while busy must be ignored.
                    drive(1'b1, ALU_AND, 1'b0);
                    #1;
                    chk({vecs[i].name, "_busy_stall"}, 32'(bus.stall), 32'd1);
                    chk({vecs[i].name, "_busy_ready"}, 32'(bus.issue_ready), 32'd0);
                    chk({vecs[i].name, "_busy_done"}, 32'(bus.op_done), 32'd0);
                end
                next_cycle();
                drive(1'b0, ALU_ADD, 1'b0);
                exp_sc = exp_sc + 32'(vecs[i].lat);
                #1;
                chk({vecs[i].name, "_done_stall"}, 32'(bus.stall), 32'd0);
                chk({vecs[i].name, "_done"}, 32'(bus.op_done), 32'd1);
                chk({vecs[i].name, "_done_op"}, 32'(bus.done_op), 32'(vecs[i].op));
                chk({vecs[i].name, "_done_ready"}, 32'(bus.issue_ready), 32'd1);
                chk({vecs[i].name, "_done_state"}, 32'(bus.state), 32'(DONE));
                chk({vecs[i].name, "_sc"}, bus.stall_cycles, exp_sc);
                next_cycle();
                #1;
                chk({vecs[i].name, "_back_idle"}, 32'(bus.state), 32'(IDLE));
                chk({vecs[i].name, "_no_repeat_done"}, 32'(bus.op_done), 32'd0);
            end
            next_cycle();
        end

        // ---------------- DIV then F_ADD in its DONE cycle ----------------
        drive(1'b1, ALU_DIV, 1'b0);
        for (int c = 1; c < 32; c++) begin
            next_cycle();
            drive(1'b0, ALU_ADD, 1'b0);
        end
        next_cycle();
        drive(1'b1, ALU_F_ADD, 1'b0);
        #1;
        chk("b2b_div_done", 32'(bus.op_done), 32'd1);
        chk("b2b_div_done_op", 32'(bus.done_op), 32'(ALU_DIV));
        chk("b2b_fadd_stall0", 32'(bus.stall), 32'd1);
        chk("b2b_ready", 32'(bus.issue_ready), 32'd1);
        next_cycle();
        drive(1'b0, ALU_ADD, 1'b0);
        #1;
        chk("b2b_fadd_stall1", 32'(bus.stall), 32'd1);
        chk("b2b_fadd_nodone", 32'(bus.op_done), 32'd0);
        next_cycle();
        exp_sc = exp_sc + 32'd34;
        #1;
        chk("b2b_fadd_done", 32'(bus.op_done), 32'd1);
        chk("b2b_fadd_done_op", 32'(bus.done_op), 32'(ALU_F_ADD));
        chk("b2b_fadd_stall2", 32'(bus.stall), 32'd0);
        chk("b2b_sc", bus.stall_cycles, exp_sc);
        next_cycle();

        // ---------------- F_DIV flushed at T+20 ----------------
        drive(1'b1, ALU_F_DIV, 1'b0);
        for (int c = 1; c < 20; c++) begin
            next_cycle();
            drive(1'b0, ALU_ADD, 1'b0);
        end
        next_cycle();
        drive(1'b1, ALU_ADD, 1'b1);
        #1;
        chk("flush_stall", 32'(bus.stall), 32'd0);
        chk("flush_done", 32'(bus.op_done), 32'd0);
        chk("flush_ready", 32'(bus.issue_ready), 32'd0);
        next_cycle();
        drive(1'b0, ALU_ADD, 1'b0);
        exp_sc = exp_sc + 32'd20;
        #1;
        chk("flush_state_idle", 32'(bus.state), 32'(IDLE));
        chk("flush_ready_after", 32'(bus.issue_ready), 32'd1);
        chk("flush_sc_kept", bus.stall_cycles, exp_sc);
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 24; c++) begin
                next_cycle();
                #1;
                if (bus.op_done || bus.stall) seen++;
            end
            chk("flush_no_late_done", 32'(seen), 32'd0);
        end
        next_cycle();

        // ---------------- flush beats DONE completion ----------------
        drive(1'b1, ALU_MUL, 1'b0);
        for (int c = 1; c < 6; c++) begin
            next_cycle();
            drive(1'b0, ALU_ADD, 1'b0);
        end
        next_cycle();
        drive(1'b0, ALU_ADD, 1'b1);
        exp_sc = exp_sc + 32'd6;
        #1;
        chk("flush_done_cycle_done", 32'(bus.op_done), 32'd0);
        chk("flush_done_cycle_ready", 32'(bus.issue_ready), 32'd0);
        next_cycle();
        drive(1'b0, ALU_ADD, 1'b0);
        #1;
        chk("flush_done_cycle_idle", 32'(bus.state), 32'(IDLE));
        chk("flush_done_cycle_nodone", 32'(bus.op_done), 32'd0);
        next_cycle();

        // ---------------- reset at T+3 of a DIV ----------------
        drive(1'b1, ALU_DIV, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            drive(1'b0, ALU_ADD, 1'b0);
        end
        rst_n = 1'b0;
        exp_sc = 32'd0;
        #1;
        chk("midrst_stall", 32'(bus.stall), 32'd0);
        chk("midrst_done", 32'(bus.op_done), 32'd0);
        chk("midrst_ready", 32'(bus.issue_ready), 32'd0);
        chk("midrst_state", 32'(bus.state), 32'(IDLE));
        chk("midrst_sc", bus.stall_cycles, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        drive(1'b1, ALU_ADD, 1'b0);
        #1;
        chk("postrst_add_done", 32'(bus.op_done), 32'd1);
        chk("postrst_add_done_op", 32'(bus.done_op), 32'(ALU_ADD));
        chk("postrst_add_stall", 32'(bus.stall), 32'd0);
        next_cycle();
        drive(1'b0, ALU_ADD, 1'b0);
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 36; c++) begin
                #1;
                if (bus.op_done || bus.stall) seen++;
                next_cycle();
            end
            chk("postrst_no_div_done", 32'(seen), 32'd0);
        end

        // ---------------- stall_cycles saturation ----------------
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        next_cycle();
        drive(1'b1, ALU_MUL, 1'b0);
        next_cycle();
        drive(1'b0, ALU_ADD, 1'b0);
        #1;
        chk("sat_first", bus.stall_cycles, 32'hFFFF_FFFF);
        for (int c = 2; c <= 6; c++) next_cycle();
        #1;
        chk("sat_done", 32'(bus.op_done), 32'd1);
        chk("sat_hold", bus.stall_cycles, 32'hFFFF_FFFF);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_op_scheduler.md
ALU_OP_SCHEDULER -- requirements
Module: alu_op_scheduler

Interface
REQ-001 Parameter: CNT_W, default 6, width of the latency down-counter; SHALL be at least 6.
REQ-002 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous and active-low.
REQ-004 Port: issue_valid  in  1  decode stage presents an ALU op.
REQ-005 Port: issue_op  in  alu_op_t  ALU operation presented.
REQ-006 Port: flush  in  1  abort any in-flight multi-cycle op (branch or trap).
REQ-007 Port: issue_ready  out  1  scheduler accepts issue_op this cycle.
REQ-008 Port: stall  out  1  freeze upstream pipeline stages; replaces the ALU's insert_bubble.
REQ-009 Port: op_done  out  1  result for the accepted op is valid on the ALU result this cycle.
REQ-010 Port: done_op  out  alu_op_t  op that op_done refers to.
REQ-011 Port: stall_cycles  out  32  saturating count of cycles with stall high.

Function
REQ-012 Latency L per op SHALL be:
- L=2: F_ADD, F_SUB, F_FLOAT_INT.
- L=6: MUL, MULH, F_MUL.
- L=32: DIV, DIVU, REM, REMU, F_INT_FLOAT.
- L=36: F_DIV, F_SQRT.
- L=0: all other ops.
REQ-013 FSM states SHALL be IDLE, BUSY and DONE.
REQ-014 issue_ready SHALL equal (state != BUSY) and not flush.
REQ-015 An op is accepted in cycle T when issue_valid and issue_ready are both high.
REQ-016 Accept with L=0: op_done=1 and done_op=issue_op combinationally in T; stall=0; next state IDLE.
REQ-017 Accept with L>0: stall=1 combinationally in T; load counter with L-1; register issue_op; next state BUSY.
REQ-018 BUSY: stall=1; counter decrements each cycle; when counter==1 the next state is DONE.
REQ-019 Latency: stall SHALL be high for exactly L cycles (T..T+L-1).
REQ-020 DONE in cycle T+L: stall=0, op_done=1, done_op=registered op, issue_ready=1.
REQ-021 DONE with a new accept SHALL behave as REQ-016/REQ-017; back-to-back ops insert zero idle cycles.
REQ-022 DONE with no accept: next state IDLE.
REQ-023 flush high in any state:
- stall=0, op_done=0 and no accept in that cycle;
- next state IDLE; counter cleared.
REQ-024 flush has priority over every other event, including DONE completion in the same cycle.
REQ-025 issue_valid low in IDLE: all outputs low except issue_ready; state holds.
REQ-026 issue_op changes while BUSY SHALL be ignored; only the registered op is tracked.
REQ-027 stall_cycles increments by 1 on each stall-high cycle and saturates at 0xFFFFFFFF; it is not cleared by flush.
REQ-028 An unknown or illegal alu_op_t value SHALL be treated as L=0.

Reset
REQ-029 rst_n low SHALL asynchronously force state=IDLE, counter=0, registered op=ALU_ADD and stall_cycles=0.
REQ-030 During reset: stall=0, op_done=0, issue_ready=0.
REQ-031 Reset assertion mid-BUSY discards the op; no op_done follows.
REQ-032 Reset deassertion is synchronized externally; the first accept is possible in the first clock after deassertion.

Structure
REQ-033 alu_latency() function and the latency constants (LAT_FADD=2, LAT_MUL=6, LAT_DIV=32, LAT_FDIV=36) SHALL live in common_pkg next to alu_op_t.
REQ-034 The scheduler state enum sched_state_t SHALL live in common_pkg.
REQ-035 No sub-module: one FSM process, one counter, one output-decode process.
REQ-036 The ALU's internal bubble counters are removed; the ALU is sequenced solely by this block's stall.

Verification
REQ-037 ADD accepted at T -> op_done=1 at T, stall=0 at T; issue_ready stays 1.
REQ-038 MUL accepted at T=10 -> stall=1 cycles 10..15; op_done=1, done_op=MUL at 16; stall_cycles=6.
REQ-039 DIV at T, F_ADD issued at its DONE cycle -> DIV op_done at T+32; F_ADD stall at T+32..T+33; F_ADD op_done at T+34.
REQ-040 F_DIV accepted, flush at T+20 -> stall=0 at T+20; state IDLE at T+21; no op_done ever for F_DIV.
REQ-041 rst_n low at T+3 of a DIV -> outputs drop immediately; after release, ADD accepted with op_done in the same cycle.
REQ-042 Force stall_cycles to 0xFFFFFFFE, run a MUL -> counter holds at 0xFFFFFFFF.
